// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits from a scanned active-low 7-segment bus, with a per-sample stability filter.
// Latency: STABLE_CNT qualifying smpl edges plus 1 clk; no backpressure, every smpl edge is consumed.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    smpl,
    input  logic                    clr_err,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [NUM_DIGITS-1:0]   dig_vld,
    output logic                    upd,
    output logic                    bad_seg
);

    localparam int                    IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]            STABLE    = 4'(STABLE_CNT);
    localparam logic [6:0]            SEG_BLANK = 7'b1111111;
    localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        KIND_LEGAL,
        KIND_BLANK,
        KIND_ILLEGAL
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [3:0] val;
    } dec_t;

    function automatic dec_t seg_decode(input logic [6:0] s);
        dec_t d;
        d.kind = KIND_LEGAL;
        d.val  = 4'd0;
        case (s)
            7'b1000000: d.val = 4'd0;
            7'b1111001: d.val = 4'd1;
            7'b0100100: d.val = 4'd2;
            7'b0110000: d.val = 4'd3;
            7'b0011001: d.val = 4'd4;
            7'b0010010: d.val = 4'd5;
            7'b0000010: d.val = 4'd6;
            7'b1111000: d.val = 4'd7;
            7'b0000000: d.val = 4'd8;
            7'b0011000: d.val = 4'd9;
            SEG_BLANK:  d.kind = KIND_BLANK;
            default:    d.kind = KIND_ILLEGAL;
        endcase
        return d;
    endfunction

    // Tracker state
    logic [6:0]       last_seg_q, last_seg_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic [3:0]       cnt_q, cnt_d;

    // Pending commit, applied one clk after the tracker reaches STABLE
    logic             cmt_vld_q, cmt_vld_d;
    logic [6:0]       cmt_seg_q, cmt_seg_d;
    logic [IDX_W-1:0] cmt_idx_q, cmt_idx_d;

    // Output registers
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   dig_vld_q, dig_vld_d;
    logic                    upd_q, upd_d;
    logic                    bad_seg_q, bad_seg_d;

    logic [NUM_DIGITS-1:0] sel;
    logic                  sel_onehot;
    logic [IDX_W-1:0]      sel_idx;
    dec_t                  cmt_dec;

    always_comb begin
        sel        = ~an;
        sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
        sel_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        last_seg_d = last_seg_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;
        cmt_vld_d  = 1'b0;
        cmt_seg_d  = cmt_seg_q;
        cmt_idx_d  = cmt_idx_q;
        if (smpl) begin
            if (!sel_onehot) begin
                cnt_d = 4'd0;
            end else if (seg == last_seg_q && sel_idx == last_idx_q) begin
                // Saturated counter means this value was already committed
                if (cnt_q != STABLE) begin
                    cnt_d     = cnt_q + 4'd1;
                    cmt_vld_d = (cnt_d == STABLE);
                end
            end else begin
                last_seg_d = seg;
                last_idx_d = sel_idx;
                cnt_d      = 4'd1;
                cmt_vld_d  = (STABLE == 4'd1);
            end
            if (cmt_vld_d) begin
                cmt_seg_d = seg;
                cmt_idx_d = sel_idx;
            end
        end
    end

    always_comb begin
        bcd_d     = bcd_q;
        dig_vld_d = dig_vld_q;
        upd_d     = 1'b0;
        bad_seg_d = clr_err ? 1'b0 : bad_seg_q;
        cmt_dec   = seg_decode(cmt_seg_q);
        if (cmt_vld_q) begin
            case (cmt_dec.kind)
                KIND_LEGAL: begin
                    upd_d = !dig_vld_q[cmt_idx_q]
                            || (bcd_q[{cmt_idx_q, 2'b00} +: 4] != cmt_dec.val);
                    bcd_d[{cmt_idx_q, 2'b00} +: 4] = cmt_dec.val;
                    dig_vld_d[cmt_idx_q]          = 1'b1;
                end
                KIND_BLANK: begin
                    upd_d                = dig_vld_q[cmt_idx_q];
                    dig_vld_d[cmt_idx_q] = 1'b0;
                end
                default: begin
                    // Setting the error outranks a simultaneous clr_err
                    upd_d                = dig_vld_q[cmt_idx_q];
                    dig_vld_d[cmt_idx_q] = 1'b0;
                    bad_seg_d            = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_seg_q <= SEG_BLANK;
            last_idx_q <= '0;
            cnt_q      <= 4'd0;
            cmt_vld_q  <= 1'b0;
            cmt_seg_q  <= SEG_BLANK;
            cmt_idx_q  <= '0;
            bcd_q      <= '0;
            dig_vld_q  <= '0;
            upd_q      <= 1'b0;
            bad_seg_q  <= 1'b0;
        end else begin
            last_seg_q <= last_seg_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
            cmt_vld_q  <= cmt_vld_d;
            cmt_seg_q  <= cmt_seg_d;
            cmt_idx_q  <= cmt_idx_d;
            bcd_q      <= bcd_d;
            dig_vld_q  <= dig_vld_d;
            upd_q      <= upd_d;
            bad_seg_q  <= bad_seg_d;
        end
    end

    assign bcd     = bcd_q;
    assign dig_vld = dig_vld_q;
    assign upd     = upd_q;
    assign bad_seg = bad_seg_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench: two decoders (4 digits / 3-sample filter, 8 digits / 1-sample filter) against a run-length reference model.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        smpl;
    logic        clr_err;
    logic [6:0]  seg;
    logic [7:0]  an;

    logic [15:0] bcd0;
    logic [3:0]  vld0;
    logic        upd0, bad0;
    logic [31:0] bcd1;
    logic [7:0]  vld1;
    logic        upd1, bad1;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an[3:0]), .smpl(smpl), .clr_err(clr_err),
        .bcd(bcd0), .dig_vld(vld0), .upd(upd0), .bad_seg(bad0)
    );

    seg7_scan_decoder #(.NUM_DIGITS(8), .STABLE_CNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .smpl(smpl), .clr_err(clr_err),
        .bcd(bcd1), .dig_vld(vld1), .upd(upd1), .bad_seg(bad1)
    );

    localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0011000};
    localparam int ND [2] = '{4, 8};
    localparam int SC [2] = '{3, 1};

    int n_cmp = 0;
    int n_err = 0;
    int upd0_n = 0;
    int upd1_n = 0;

    // Reference model: digit contents plus the current run of identical samples
    int         m_bcd [2][8];
    bit         m_vld [2][8];
    bit         m_bad [2];
    bit         m_upd [2];
    logic [6:0] r_seg [2];
    int         r_idx [2];
    int         r_len [2];
    bit         p_vld [2];
    logic [6:0] p_seg [2];
    int         p_idx [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // -1 illegal, 10 blank, else digit value
    function automatic int dec(input logic [6:0] s);
        for (int v = 0; v < 10; v++) begin
            if (PAT[v] == s) return v;
        end
        if (s == 7'h7F) return 10;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) begin
                m_bcd[k][i] = 0;
                m_vld[k][i] = 0;
            end
            m_bad[k] = 0; m_upd[k] = 0;
            r_seg[k] = 7'h7F; r_idx[k] = 0; r_len[k] = 0;
            p_vld[k] = 0; p_seg[k] = 7'h7F; p_idx[k] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int k = 0; k < 2; k++) begin
            int v, i, lows, idx;
            m_upd[k] = 0;
            if (clr_err) m_bad[k] = 0;
            if (p_vld[k]) begin
                v = dec(p_seg[k]);
                i = p_idx[k];
                if (v >= 0 && v < 10) begin
                    if (!m_vld[k][i] || m_bcd[k][i] != v) m_upd[k] = 1;
                    m_bcd[k][i] = v;
                    m_vld[k][i] = 1;
                end else begin
                    if (m_vld[k][i]) m_upd[k] = 1;
                    m_vld[k][i] = 0;
                    if (v < 0) m_bad[k] = 1;
                end
            end
            p_vld[k] = 0;
            if (smpl) begin
                lows = 0; idx = 0;
                for (int b = 0; b < ND[k]; b++) begin
                    if (!an[b]) begin lows++; idx = b; end
                end
                if (lows == 1) begin
                    if (seg == r_seg[k] && idx == r_idx[k]) r_len[k]++;
                    else begin r_seg[k] = seg; r_idx[k] = idx; r_len[k] = 1; end
                    if (r_len[k] == SC[k]) begin
                        p_vld[k] = 1; p_seg[k] = seg; p_idx[k] = idx;
                    end
                end else begin
                    r_len[k] = 0;
                end
            end
        end
    endfunction

    function automatic logic [31:0] exp_bcd(input int k);
        logic [31:0] r = '0;
        for (int i = 0; i < ND[k]; i++) r[4*i +: 4] = m_bcd[k][i][3:0];
        return r;
    endfunction

    function automatic logic [31:0] exp_vld(input int k);
        logic [31:0] r = '0;
        for (int i = 0; i < ND[k]; i++) r[i] = m_vld[k][i];
        return r;
    endfunction

    task automatic check_all();
        chk("bcd0", 32'(bcd0), exp_bcd(0));
        chk("vld0", 32'(vld0), exp_vld(0));
        chk("upd0", 32'(upd0), 32'(m_upd[0]));
        chk("bad0", 32'(bad0), 32'(m_bad[0]));
        chk("bcd1", bcd1, exp_bcd(1));
        chk("vld1", 32'(vld1), exp_vld(1));
        chk("upd1", 32'(upd1), 32'(m_upd[1]));
        chk("bad1", 32'(bad1), 32'(m_bad[1]));
    endtask

    task automatic step(input logic s, input logic [6:0] sg, input logic [7:0] a, input logic ce);
        smpl = s; seg = sg; an = a; clr_err = ce;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (upd0) upd0_n++;
        if (upd1) upd1_n++;
    endtask

    task automatic run(input int n, input logic [6:0] sg, input logic [7:0] a);
        for (int j = 0; j < n; j++) step(1'b1, sg, a, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 7'h7F, 8'hFF, 1'b0);
    endtask

    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        rst_n = 1'b0; smpl = 1'b1; seg = 7'b0110000; an = 8'hFE; clr_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bcd0", 32'(bcd0), 32'h0);
        chk("rst_vld0", 32'(vld0), 32'h0);
        chk("rst_upd0", 32'(upd0), 32'h0);
        chk("rst_bad0", 32'(bad0), 32'h0);
        chk("rst_bcd1", bcd1, 32'h0);
        chk("rst_vld1", 32'(vld1), 32'h0);
        rst_n = 1'b1;

        // First commit: three samples of '3' on digit 0, output one clk later
        run(3, PAT[3], 8'hFE);
        chk("first_pre_vld0", 32'(vld0), 32'h0);
        idle();
        chk("first_bcd0", 32'(bcd0[3:0]), 32'd3);
        chk("first_vld0", 32'(vld0), 32'h1);
        chk("first_upd0", 32'(upd0), 32'h1);
        idle();
        chk("first_upd0_low", 32'(upd0), 32'h0);

        // Glitch filter on digit 1
        base = upd0_n;
        run(2, PAT[5], 8'hFD);
        run(3, PAT[6], 8'hFD);
        idle();
        chk("glitch_bcd0", 32'(bcd0[7:4]), 32'd6);
        chk("glitch_upd_cnt", 32'(upd0_n - base), 32'd1);

        // Full scan, then identical rescan
        for (int d = 0; d < 4; d++) run(3, PAT[d+1], ~(8'h01 << d));
        idle();
        chk("scan_bcd0", 32'(bcd0), 32'h4321);
        chk("scan_vld0", 32'(vld0), 32'hF);
        base = upd0_n;
        for (int d = 0; d < 4; d++) run(3, PAT[d+1], ~(8'h01 << d));
        idle();
        chk("rescan_upd_cnt", 32'(upd0_n - base), 32'd0);

        // Illegal, blank, clear and set-wins on digit 2
        run(3, 7'b1010101, 8'hFB);
        idle();
        chk("ill_vld2", 32'(vld0[2]), 32'h0);
        chk("ill_bad0", 32'(bad0), 32'h1);
        chk("ill_bcd2", 32'(bcd0[11:8]), 32'd3);
        run(3, 7'h7F, 8'hFB);
        idle();
        chk("blank_vld2", 32'(vld0[2]), 32'h0);
        chk("blank_bad0", 32'(bad0), 32'h1);
        step(1'b0, 7'h7F, 8'hFF, 1'b1);
        chk("clr_bad0", 32'(bad0), 32'h0);
        run(2, 7'b0001111, 8'hFB);
        step(1'b1, 7'b0001111, 8'hFB, 1'b1);
        step(1'b0, 7'h7F, 8'hFF, 1'b1);
        chk("setwins_bad0", 32'(bad0), 32'h1);

        // Bad selects restart the run; smpl=0 cycles do not
        run(2, PAT[7], 8'hFE);
        step(1'b1, PAT[7], 8'hFC, 1'b0);
        run(2, PAT[7], 8'hFE);
        idle();
        chk("badsel_hold", 32'(bcd0[3:0]), 32'd1);
        run(1, PAT[7], 8'hFE);
        idle();
        chk("badsel_commit", 32'(bcd0[3:0]), 32'd7);
        for (int j = 0; j < 2; j++) begin run(1, PAT[8], 8'hFE); idle(); end
        step(1'b1, PAT[8], 8'hFF, 1'b0);
        for (int j = 0; j < 2; j++) begin run(1, PAT[8], 8'hFE); idle(); end
        chk("gap_hold", 32'(bcd0[3:0]), 32'd7);
        run(1, PAT[8], 8'hFE);
        idle();
        chk("gap_commit", 32'(bcd0[3:0]), 32'd8);

        // Async reset after 2 of 3 samples
        run(2, PAT[9], 8'hF7);
        mid_reset();
        chk("mrst_vld0", 32'(vld0), 32'h0);
        run(2, PAT[9], 8'hF7);
        idle();
        chk("mrst_nocommit", 32'(vld0), 32'h0);
        run(1, PAT[9], 8'hF7);
        idle();
        chk("mrst_bcd3", 32'(bcd0[15:12]), 32'd9);
        chk("mrst_vld3", 32'(vld0), 32'h8);

        // Back-to-back single-sample commits on digit 5 of the 8-digit decoder
        base = upd1_n;
        run(1, PAT[1], 8'hDF);
        run(1, PAT[2], 8'hDF);
        run(1, PAT[1], 8'hDF);
        run(1, PAT[2], 8'hDF);
        idle();
        idle();
        chk("b2b_upd_cnt", 32'(upd1_n - base), 32'd4);

        // Randomized traffic
        for (int t = 0; t < 700; t++) begin
            int r, hold;
            logic [6:0] sg;
            logic [7:0] a;
            r = $urandom_range(0, 9);
            if (r < 6)      sg = PAT[$urandom_range(0, 9)];
            else if (r < 8) sg = 7'h7F;
            else            sg = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) < 8) a = ~(8'h01 << $urandom_range(0, 7));
            else                          a = 8'($urandom);
            hold = $urandom_range(1, 5);
            for (int j = 0; j < hold; j++)
                step($urandom_range(0, 9) < 8, sg, a, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) mid_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
